processor_seq: RTL and testbench
================================

PROCESSOR_SEQ -- requirements
Module: processor_seq

Interface
REQ-001 The block SHALL have one parameter: COUNT_W, default 8, width of the retired-instruction counter.
REQ-002 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request pulse (from the debouncer) to execute instr.
REQ-005 instr  input  16  instruction: [15] use-carry, [14:12] ALU op, [11:8] immediate, [7:6] mode, [5:4] dst, [3:2] src_p, [1:0] src_q.
REQ-006 alu_f  input  4  ALU result.
REQ-007 alu_cout  input  1  ALU carry-out.
REQ-008 rp_addr, rq_addr  output  2 each  register-file read addresses.
REQ-009 w_addr  output  2  register-file write address.
REQ-010 w_data  output  4  register-file write data.
REQ-011 w_ena  output  1  register-file write enable.
REQ-012 alu_sel  output  3  ALU op select; alu_cin  output  1  ALU carry-in.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 carry_flag  output  1  stored carry.
REQ-016 instr_count  output  COUNT_W  number of retired instructions.

Function
REQ-017 States SHALL be IDLE, READ, EXEC, WRITE, DONE.
REQ-018 In IDLE with start=1, instr SHALL be latched into an internal register; all later outputs derive only from the latched copy.
REQ-019 Mode 00 (NOP): IDLE->DONE.
REQ-020 Mode 01 (LOADI): IDLE->WRITE, with w_data = imm.
REQ-021 Mode 10 (ALU): IDLE->READ->EXEC->WRITE->DONE, with w_data = the captured result.
REQ-022 Mode 11 (compare): IDLE->READ->EXEC->DONE, with no write.
REQ-023 In READ and EXEC, rp_addr and rq_addr SHALL equal src_p and src_q, and alu_sel SHALL equal op; otherwise all three SHALL be 0.
REQ-024 At the end of EXEC, alu_f SHALL be captured into a 4-bit result register.
REQ-025 w_ena SHALL be 1 exactly during the single WRITE cycle, with w_addr = dst; w_addr and w_data SHALL be 0 outside WRITE.
REQ-026 DONE SHALL last one cycle: done=1, instr_count increments (wrapping from all-ones to 0), and the next state is IDLE.
REQ-027 Latency from the start-accept edge to done: ALU 4 cycles; compare 3; LOADI 2; NOP 1.
REQ-028 start SHALL be ignored whenever busy=1, including in DONE; no queueing.
REQ-029 Back-to-back instructions SHALL be possible: start in the cycle after DONE is accepted.

Reset
REQ-030 Assertion of rst SHALL immediately force IDLE, clear the latched instruction, result, carry_flag and instr_count, and drive all outputs to 0, including mid-operation.
REQ-031 An interrupted instruction SHALL NOT write, SHALL NOT pulse done and SHALL NOT count.
REQ-032 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-033 Macro PROC_SEQ_CARRY_CHAIN_EN defined: carry_flag is loaded from alu_cout at the end of EXEC (modes 10/11), and alu_cin = instr[15] AND carry_flag during READ/EXEC.
REQ-034 Macro PROC_SEQ_CARRY_CHAIN_EN undefined: no carry register; carry_flag is tied 0, and alu_cin = instr[15] during READ/EXEC, otherwise 0.

Verification
REQ-035 Reset then start with instr=16'h0150 (LOADI imm=1, dst=1) -> w_ena=1 one cycle later with w_addr=1 and w_data=1; done the cycle after; instr_count=1.
REQ-036 ALU instr mode 10, op=3'b000, dst=2, src_p=1, src_q=0, alu_f driven 4'hA -> rp_addr=1, rq_addr=0 for 2 cycles; w_ena with w_addr=2 and w_data=A; done 4 cycles after accept.
REQ-037 start pulsed in READ, EXEC, WRITE and DONE -> no extra instruction executes; instr_count advances by 1 only.
REQ-038 rst asserted during EXEC -> w_ena and done stay 0 and all outputs read 0 within the same cycle; the next start executes normally.
REQ-039 Macro defined: compare with alu_cout=1, then ALU with instr[15]=1 -> alu_cin=1 in the second instruction; undefined -> alu_cin=instr[15] and carry_flag=0 throughout.
REQ-040 With COUNT_W=2, retire 5 NOPs -> instr_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/processor_seq.sv
// Multi-cycle instruction sequencer driving an external register file and ALU.
// Optional carry chain between instructions: define PROC_SEQ_CARRY_CHAIN_EN.
module processor_seq #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        instr,
  input  logic [3:0]         alu_f,
  input  logic               alu_cout,
  output logic [1:0]         rp_addr,
  output logic [1:0]         rq_addr,
  output logic [1:0]         w_addr,
  output logic [3:0]         w_data,
  output logic               w_ena,
  output logic [2:0]         alu_sel,
  output logic               alu_cin,
  output logic               busy,
  output logic               done,
  output logic               carry_flag,
  output logic [COUNT_W-1:0] instr_count,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_NOP   = 2'b00;
  localparam logic [1:0] MODE_LOADI = 2'b01;
  localparam logic [1:0] MODE_ALU   = 2'b10;
  localparam logic [1:0] MODE_CMP   = 2'b11;

  state_t             state;
  state_t             state_next;
  logic [15:0]        instr_q;
  logic [3:0]         result_q;
  logic [COUNT_W-1:0] count_q;

  // Fields of the latched instruction; nothing downstream looks at the live input.
  logic       use_carry;
  logic [2:0] op;
  logic [3:0] imm;
  logic [1:0] mode;
  logic [1:0] dst;
  logic [1:0] src_p;
  logic [1:0] src_q;

  assign use_carry = instr_q[15];
  assign op        = instr_q[14:12];
  assign imm       = instr_q[11:8];
  assign mode      = instr_q[7:6];
  assign dst       = instr_q[5:4];
  assign src_p     = instr_q[3:2];
  assign src_q     = instr_q[1:0];

  logic accept;
  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= '0;
    end else if (accept) begin
      instr_q <= instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
    end else if (state == EXEC) begin
      result_q <= alu_f;
    end
  end

  // Counts on leaving DONE, so an aborted instruction never retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (state == DONE) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign instr_count = count_q;
  assign dbg_state   = state;

`ifdef PROC_SEQ_CARRY_CHAIN_EN
  logic carry_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_q <= 1'b0;
    end else if (state == EXEC) begin
      carry_q <= alu_cout;
    end
  end

  assign carry_flag = carry_q;

  logic cin_value;
  assign cin_value = use_carry & carry_q;
`else
  logic unused_cout;
  assign unused_cout = alu_cout;
  assign carry_flag  = 1'b0;

  logic cin_value;
  assign cin_value = use_carry;
`endif

  // Handshake: start is a one-cycle request honoured only in IDLE (busy=0);
  // requests while busy are dropped, and done pulses once per retired instruction.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (instr[7:6])
            MODE_NOP:   state_next = DONE;
            MODE_LOADI: state_next = WRITE;
            MODE_ALU:   state_next = READ;
            MODE_CMP:   state_next = READ;
            default:    state_next = IDLE;
          endcase
        end
      end
      READ:    state_next = EXEC;
      EXEC:    state_next = (mode == MODE_ALU) ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rp_addr = '0;
    rq_addr = '0;
    alu_sel = '0;
    alu_cin = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    w_ena   = 1'b0;
    done    = 1'b0;
    busy    = (state != IDLE);
    unique case (state)
      READ, EXEC: begin
        rp_addr = src_p;
        rq_addr = src_q;
        alu_sel = op;
        alu_cin = cin_value;
      end
      WRITE: begin
        w_ena  = 1'b1;
        w_addr = dst;
        w_data = (mode == MODE_LOADI) ? imm : result_q;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_processor_seq.sv
// Randomized scoreboard bench for processor_seq: the driver predicts every busy
// cycle from the instruction rules, the monitor checks what the DUT presents.
module tb_processor_seq;

  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [15:0]   instr;
  logic [3:0]    alu_f;
  logic          alu_cout;
  logic [1:0]    rp_addr;
  logic [1:0]    rq_addr;
  logic [1:0]    w_addr;
  logic [3:0]    w_data;
  logic          w_ena;
  logic [2:0]    alu_sel;
  logic          alu_cin;
  logic          busy;
  logic          done;
  logic          carry_flag;
  logic [CW-1:0] instr_count;
  logic [2:0]    dbg_state;

  processor_seq #(.COUNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .instr       (instr),
    .alu_f       (alu_f),
    .alu_cout    (alu_cout),
    .rp_addr     (rp_addr),
    .rq_addr     (rq_addr),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .w_ena       (w_ena),
    .alu_sel     (alu_sel),
    .alu_cin     (alu_cin),
    .busy        (busy),
    .done        (done),
    .carry_flag  (carry_flag),
    .instr_count (instr_count),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Expected per-busy-cycle output image:
  // {cyc[15:0], rp, rq, sel, cin, w_addr, w_data, w_ena, done, carry_flag}
  localparam int W = 33;
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] cnt_q[$];

  int model_count = 0;
  logic model_carry = 1'b0;

  function automatic logic [W-1:0] ev(input int c, input logic [1:0] rp, input logic [1:0] rq,
                                      input logic [2:0] sel, input logic cin, input logic [1:0] wa,
                                      input logic [3:0] wd, input logic we, input logic dn,
                                      input logic cf);
    return {16'(c), rp, rq, sel, cin, wa, wd, we, dn, cf};
  endfunction

  // monitor / scoreboard
  logic cnt_due = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0]  obs;
    logic [W-1:0]  exp;
    logic [CW-1:0] exp_cnt;
    obs = ev(cyc, rp_addr, rq_addr, alu_sel, alu_cin, w_addr, w_data, w_ena, done, carry_flag);
    if (cnt_due) begin
      total++;
      if (cnt_q.size() == 0) begin
        bad++;
        $display("FAIL count_unexpected cyc=%0d got=%0d", cyc, instr_count);
      end else begin
        exp_cnt = cnt_q.pop_front();
        if (instr_count !== exp_cnt) begin
          bad++;
          $display("FAIL instr_count cyc=%0d got=%0d exp=%0d", cyc, instr_count, exp_cnt);
        end
      end
    end
    cnt_due = (done === 1'b1);
    while (exp_q.size() > 0 && int'(exp_q[0][32:17]) < (cyc & 16'hffff)) begin
      exp = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missed_event cyc=%0d exp=%h", cyc, exp);
    end
    if (busy === 1'b1) begin
      total++;
      if (exp_q.size() == 0 || int'(exp_q[0][32:17]) != (cyc & 16'hffff)) begin
        bad++;
        $display("FAIL unexpected_busy cyc=%0d got=%h", cyc, obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          bad++;
          $display("FAIL busy_cycle cyc=%0d got=%h exp=%h", cyc, obs, exp);
        end
      end
    end else begin
      total++;
      if (exp_q.size() > 0 && int'(exp_q[0][32:17]) == (cyc & 16'hffff)) begin
        exp = exp_q.pop_front();
        bad++;
        $display("FAIL idle_not_busy cyc=%0d got=%h exp=%h", cyc, obs, exp);
      end else if (obs[16:1] !== '0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_outputs cyc=%0d got=%h exp=0", cyc, obs[16:1]);
      end
    end
  end

  // driver tasks: each is entered and left at posedge+1
  task automatic idle(input int n);
    repeat (n) begin
      start    = 1'b0;
      instr    = 16'($urandom);
      alu_f    = 4'($urandom);
      alu_cout = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic [3:0] vf, input logic vc,
                           input bit spur);
    int         a;
    int         lat;
    logic       cb;
    logic       ca;
    logic       cin_e;
    logic [1:0] dst;
    logic [W-1:0] rd0;
    logic [W-1:0] rd1;
    a   = cyc + 1;
    dst = ins[5:4];
    cb  = model_carry;
`ifdef PROC_SEQ_CARRY_CHAIN_EN
    cin_e = ins[15] & model_carry;
    ca    = ins[7] ? vc : model_carry;
`else
    cin_e = ins[15];
    ca    = 1'b0;
`endif
    rd0 = ev(a,     ins[3:2], ins[1:0], ins[14:12], cin_e, 2'd0, 4'd0, 1'b0, 1'b0, cb);
    rd1 = ev(a + 1, ins[3:2], ins[1:0], ins[14:12], cin_e, 2'd0, 4'd0, 1'b0, 1'b0, cb);
    case (ins[7:6])
      2'b00: begin
        lat = 1;
        exp_q.push_back(ev(a, 0, 0, 0, 0, 0, 0, 0, 1, cb));
      end
      2'b01: begin
        lat = 2;
        exp_q.push_back(ev(a,     0, 0, 0, 0, dst, ins[11:8], 1, 0, cb));
        exp_q.push_back(ev(a + 1, 0, 0, 0, 0, 0,   0,         0, 1, cb));
      end
      2'b10: begin
        lat = 4;
        exp_q.push_back(rd0);
        exp_q.push_back(rd1);
        exp_q.push_back(ev(a + 2, 0, 0, 0, 0, dst, vf, 1, 0, ca));
        exp_q.push_back(ev(a + 3, 0, 0, 0, 0, 0,   0,  0, 1, ca));
      end
      default: begin
        lat = 3;
        exp_q.push_back(rd0);
        exp_q.push_back(rd1);
        exp_q.push_back(ev(a + 2, 0, 0, 0, 0, 0, 0, 0, 1, ca));
      end
    endcase
    model_count = (model_count + 1) % (1 << CW);
    cnt_q.push_back(CW'(model_count));
    start    = 1'b1;
    instr    = ins;
    alu_f    = 4'($urandom);
    alu_cout = 1'($urandom);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      start    = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      instr    = 16'($urandom);
      alu_f    = (k == 2) ? vf : 4'($urandom);
      alu_cout = (k == 2) ? vc : 1'($urandom);
    end
    @(posedge clk); #1;
    start       = 1'b0;
    model_carry = ca;
  endtask

  // Start an ALU instruction and pull reset in the middle of its EXEC cycle.
  task automatic run_abort(input logic [15:0] ins);
    int   a;
    logic cin_e;
    a = cyc + 1;
`ifdef PROC_SEQ_CARRY_CHAIN_EN
    cin_e = ins[15] & model_carry;
`else
    cin_e = ins[15];
`endif
    exp_q.push_back(ev(a, ins[3:2], ins[1:0], ins[14:12], cin_e, 0, 0, 0, 0, model_carry));
    start = 1'b1;
    instr = ins;
    @(posedge clk); #1;
    start = 1'b0;
    instr = 16'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++;
    if ({rp_addr, rq_addr, alu_sel, alu_cin, w_addr, w_data, w_ena, busy, done, carry_flag} !== '0) begin
      bad++;
      $display("FAIL reset_outputs t=%0t got=%h exp=0", $time,
               {rp_addr, rq_addr, alu_sel, alu_cin, w_addr, w_data, w_ena, busy, done, carry_flag});
    end
    total++;
    if (instr_count !== '0) begin
      bad++;
      $display("FAIL reset_count got=%0d exp=0", instr_count);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL reset_pending got=%0d exp=0", exp_q.size());
    end
    exp_q.delete();
    model_count = 0;
    model_carry = 1'b0;
    @(posedge clk); #1;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    logic [15:0] ins;
    rst      = 1'b1;
    start    = 1'b0;
    instr    = '0;
    alu_f    = '0;
    alu_cout = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    idle(3);
    rst = 1'b1;
    // first start on the first edge after reset release
    run_instr(16'h0150, 4'($urandom), 1'($urandom), 1'b0);
    run_instr(16'h00A4, 4'hA, 1'b0, 1'b0);
    idle(2);
    run_instr(16'h2F96, 4'h5, 1'b1, 1'b1);
    run_instr(16'h30D6, 4'h3, 1'b1, 1'b1);
    run_instr(16'h9096, 4'hC, 1'b0, 1'b0);
    idle(1);
    run_abort(16'h10A7);
    for (int i = 0; i < 5; i++) run_instr(16'h0000 | 16'(i), 4'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < 200; i++) begin
      ins = 16'($urandom);
      run_instr(ins, 4'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    run_abort(16'($urandom) & 16'hFF3F | 16'h0080);
    run_instr(16'h0150, 4'($urandom), 1'($urandom), 1'b0);
    idle(4);
    total++;
    if (exp_q.size() != 0 || cnt_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events got=%0d/%0d exp=0/0", exp_q.size(), cnt_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
